// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first.
// A three-state FSM (IDLE/RUN/DONE) sequences the operation. The result and
// final borrow land in output registers only when the last bit is processed,
// so d/bout never show a partial result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter indexes bits 0..WIDTH-1; WIDTH >= 2 keeps this at least one bit.
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] d_reg;
    logic             bout_reg;

    logic             ai;
    logic             bi;
    logic             diff_bit;
    logic             borrow_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor on the current LSBs of the operand shift registers.
    always_comb begin
        ai          = a_sh_reg[0];
        bi          = b_sh_reg[0];
        diff_bit    = ai ^ bi ^ borrow_reg;
        borrow_next = (~ai & bi) | (~(ai ^ bi) & borrow_reg);
        // New diff bit enters at the MSB; after WIDTH shifts bit i sits at i.
        res_next    = {diff_bit, res_reg[WIDTH-1:1]};
    end

    // FSM plus datapath; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            res_reg    <= '0;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            d_reg      <= '0;
            bout_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg   <= a;
                        b_sh_reg   <= b;
                        borrow_reg <= bin;
                        res_reg    <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    borrow_reg <= borrow_next;
                    res_reg    <= res_next;
                    cnt_reg    <= cnt_reg + ONE;
                    if (cnt_reg == LAST) begin
                        // Publish the completed result on the edge into DONE.
                        d_reg     <= res_next;
                        bout_reg  <= borrow_next;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg == RUN) || (state_reg == DONE);
    assign done = (state_reg == DONE);
    assign d    = d_reg;
    assign bout = bout_reg;

endmodule
